// File: rtl/pwconv_gen_pkg.sv
// Shared definitions for the pointwise-convolution generator: FSM encoding,
// accumulator sizing and the round / ReLU / saturate requantizer.
package pwconv_gen_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_QUANT = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic int acc_width(input int data_w, input int filter_w, input int in_ch);
    return data_w + filter_w + $clog2(in_ch) + 1;
  endfunction

  // Round-half-up arithmetic shift, optional ReLU, then clamp to a data_w-bit signed range.
  function automatic logic signed [MAX_W-1:0] requant(
    input logic signed [MAX_W-1:0] acc,
    input logic [4:0]              shift,
    input logic                    relu,
    input int                      data_w
  );
    logic signed [MAX_W-1:0] rnd;
    logic signed [MAX_W-1:0] val;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    if (shift != 5'd0) begin
      rnd = 64'sd1 <<< (shift - 5'd1);
    end else begin
      rnd = 64'sd0;
    end
    val = (acc + rnd) >>> shift;
    if (relu && (val < 64'sd0)) begin
      val = 64'sd0;
    end else begin
      val = val;
    end
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (val > hi) begin
      val = hi;
    end else if (val < lo) begin
      val = lo;
    end else begin
      val = val;
    end
    return val;
  endfunction

endpackage

// File: rtl/pwconv_gen_pe.sv
// One processing element: LANES signed multipliers per step, a registered
// partial-sum stage, and a bias-seeded accumulator.
module pwconv_gen_pe
  import pwconv_gen_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int FILTER_W = 8,
  parameter int BIAS_W   = 16,
  parameter int IN_CH    = 32,
  parameter int LANES    = 2,
  parameter int ACC_W    = acc_width(DATA_W, FILTER_W, IN_CH),
  parameter int STEP_W   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_issue,
  input  logic [STEP_W-1:0]          i_step,
  input  logic [IN_CH*DATA_W-1:0]    i_pix,
  input  logic [IN_CH*FILTER_W-1:0]  i_wgt,
  input  logic signed [BIAS_W-1:0]   i_bias,
  output logic signed [ACC_W-1:0]    o_acc
);

  logic signed [DATA_W-1:0]          w_a;
  logic signed [FILTER_W-1:0]        w_b;
  logic signed [DATA_W+FILTER_W-1:0] w_prod;
  logic signed [ACC_W-1:0]           w_psum;
  logic signed [ACC_W-1:0]           w_bias_ext;
  int                                w_sel;

  logic signed [ACC_W-1:0]           r_psum;
  logic                              r_psum_vld;
  logic                              r_psum_first;
  logic signed [ACC_W-1:0]           r_acc;

  assign w_bias_ext = ACC_W'(i_bias);
  assign o_acc      = r_acc;

  // Sum of the LANES channel products selected by the current step.
  always_comb begin
    w_a    = '0;
    w_b    = '0;
    w_prod = '0;
    w_psum = '0;
    w_sel  = i_issue ? int'(i_step) : 0;
    for (int l = 0; l < LANES; l++) begin
      w_a    = i_pix[(w_sel*LANES + l)*DATA_W +: DATA_W];
      w_b    = i_wgt[(w_sel*LANES + l)*FILTER_W +: FILTER_W];
      w_prod = w_a * w_b;
      w_psum = w_psum + ACC_W'(w_prod);
    end
  end

  // Partial sum lands one cycle after issue; the step-0 sum replaces the old total with the bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum       <= '0;
      r_psum_vld   <= 1'b0;
      r_psum_first <= 1'b0;
      r_acc        <= '0;
    end else begin
      r_psum_vld   <= i_issue;
      r_psum_first <= i_issue && (i_step == STEP_W'(0));
      if (i_issue) begin
        r_psum <= w_psum;
      end
      if (r_psum_vld) begin
        r_acc <= (r_psum_first ? w_bias_ext : r_acc) + r_psum;
      end
    end
  end

endmodule

// File: rtl/pwconv_gen.sv
// Pointwise convolution over PIX_NUM pixels: captures a job, accumulates
// IN_CH channels LANES at a time, requantizes and holds the result for a handshake.
module pwconv_gen
  import pwconv_gen_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int FILTER_W = 8,
  parameter int BIAS_W   = 16,
  parameter int IN_CH    = 32,
  parameter int LANES    = 2,
  parameter int PIX_NUM  = 36
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  output logic                              ready_o,
  input  logic [PIX_NUM*IN_CH*DATA_W-1:0]   pixel_i,
  input  logic [IN_CH*FILTER_W-1:0]         weight_i,
  input  logic signed [BIAS_W-1:0]          bias_i,
  input  logic [4:0]                        shift_i,
  input  logic                              relu_en_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [PIX_NUM*DATA_W-1:0]         pixel_o
);

  localparam int ACC_W  = acc_width(DATA_W, FILTER_W, IN_CH);
  localparam int STEPS  = IN_CH / LANES;
  localparam int STEP_W = $clog2(STEPS + 1);

  if ((IN_CH % LANES) != 0) begin : g_bad_lanes
    $error("IN_CH must be a multiple of LANES");
  end
  if (BIAS_W > ACC_W) begin : g_bad_bias
    $error("BIAS_W must not exceed the accumulator width");
  end
  if (ACC_W > MAX_W - 2) begin : g_bad_acc
    $error("accumulator too wide for the requantizer");
  end

  state_t                             r_state;
  logic [STEP_W-1:0]                  r_step;
  logic                               r_ready;
  logic                               r_valid;
  logic [PIX_NUM*DATA_W-1:0]          r_pix_o;
  logic [PIX_NUM*IN_CH*DATA_W-1:0]    r_pix;
  logic [IN_CH*FILTER_W-1:0]          r_wgt;
  logic signed [BIAS_W-1:0]           r_bias;
  logic [4:0]                         r_shift;
  logic                               r_relu;

  logic                               w_issue;
  logic [PIX_NUM*DATA_W-1:0]          w_q;

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign pixel_o = r_pix_o;

  // Steps 0..STEPS-1 issue products; step STEPS only drains the last partial sum.
  assign w_issue = (r_state == ST_ACC) && (r_step != STEP_W'(STEPS));

  for (genvar p = 0; p < PIX_NUM; p++) begin : g_pe
    logic signed [ACC_W-1:0] w_acc;
    logic signed [MAX_W-1:0] w_rq;
    logic                    w_unused_hi;

    pwconv_gen_pe #(
      .DATA_W   (DATA_W),
      .FILTER_W (FILTER_W),
      .BIAS_W   (BIAS_W),
      .IN_CH    (IN_CH),
      .LANES    (LANES),
      .ACC_W    (ACC_W),
      .STEP_W   (STEP_W)
    ) u_pe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_issue (w_issue),
      .i_step  (r_step),
      .i_pix   (r_pix[p*IN_CH*DATA_W +: IN_CH*DATA_W]),
      .i_wgt   (r_wgt),
      .i_bias  (r_bias),
      .o_acc   (w_acc)
    );

    assign w_rq        = requant(MAX_W'(w_acc), r_shift, r_relu, DATA_W);
    assign w_q[p*DATA_W +: DATA_W] = w_rq[DATA_W-1:0];
    assign w_unused_hi = ^w_rq[MAX_W-1:DATA_W];
  end

  // Control FSM with job capture and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_pix_o <= '0;
      r_pix   <= '0;
      r_wgt   <= '0;
      r_bias  <= '0;
      r_shift <= 5'd0;
      r_relu  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_pix   <= pixel_i;
            r_wgt   <= weight_i;
            r_bias  <= bias_i;
            r_shift <= shift_i;
            r_relu  <= relu_en_i;
            r_step  <= '0;
            r_ready <= 1'b0;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (r_step == STEP_W'(STEPS)) begin
            r_step  <= '0;
            r_state <= ST_QUANT;
          end else begin
            r_step  <= r_step + STEP_W'(1);
          end
        end
        ST_QUANT: begin
          r_pix_o <= w_q;
          r_valid <= 1'b1;
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_step  <= '0;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
